uart_tx_sched: RTL
==================

# uart_tx_sched

Transmit scheduler sitting between the APB register block and the UART transmitter. Buffers bytes written by software in a DEPTH-entry FIFO and launches frames one at a time through the transmitter's `tx_enable`/`tx_busy` handshake. Latches the frame configuration at each launch so register writes during a frame never corrupt it. Reports FIFO level, overflow and per-frame completion.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `AW`, 4: log2(DEPTH).
- `THRESH`, 4: low-water level for `tx_irq`; 0 ≤ THRESH < DEPTH.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sched_en`  in  1  allow new frame launches.
- `cfg_in`  in  5  frame config from register block: [1:0] data bits-5, [2] two stop bits, [3] parity enable, [4] odd parity.
- `wr_valid`  in  1  software write strobe.
- `wr_data`  in  8  byte to enqueue.
- `wr_ready`  out  1  equals `!fifo_full`.
- `flush`  in  1  discard all queued bytes.
- `tx_enable`  out  1  one-cycle launch pulse to transmitter.
- `tx_data`  out  8  byte presented to transmitter, held until next launch.
- `cfg_reg`  out  5  config latched at launch, held until next launch.
- `tx_busy`  in  1  transmitter busy.
- `fifo_count`  out  AW+1  entries queued, 0..DEPTH.
- `fifo_empty`  out  1  `fifo_count == 0`.
- `fifo_full`  out  1  `fifo_count == DEPTH`.
- `sched_idle`  out  1  state IDLE and FIFO empty.
- `frame_sent`  out  1  one-cycle pulse per completed frame.
- `ovf`  out  1  one-cycle pulse when a write is dropped because FIFO full.
- `tx_irq`  out  1  low-water interrupt (see Configuration).

## Operation
- FIFO: AW-bit read/write pointers with natural wrap, separate AW+1-bit count; all flags registered, derived from count.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: if `sched_en && !fifo_empty && !tx_busy && !flush`: pop head into `tx_data`, copy `cfg_in` into `cfg_reg`, drive `tx_enable`=1 next cycle, go WAIT_BUSY.
- WAIT_BUSY: `tx_enable` high exactly this first cycle only; stay until `tx_busy`=1, then go WAIT_DONE.
- WAIT_DONE: stay while `tx_busy`=1; on `tx_busy`=0 pulse `frame_sent`, go IDLE.
- Write: accepted when `wr_valid && !fifo_full` (full as of cycle start); else dropped with `ovf` pulse.
- Write and pop in same cycle: both occur, count unchanged; write on full is dropped even if a pop occurs that cycle.
- `flush`: count and pointers to 0 next cycle; overrides same-cycle write (no `ovf`) and blocks same-cycle launch. An in-flight frame is not aborted and still produces `frame_sent`.
- `sched_en` deasserted mid-frame: current frame completes; no further launches.
- Bytes are sent strictly in write order; `tx_data`/`cfg_reg` never change between launch and `frame_sent`.

## Timing
- Reset values: `tx_enable` 0, `tx_data` 0, `cfg_reg` 0, `fifo_count` 0, `fifo_empty` 1, `fifo_full` 0, `wr_ready` 1, `sched_idle` 1, `frame_sent` 0, `ovf` 0, `tx_irq` 0; state IDLE.
- Write at edge N → `fifo_count`/flags updated at N+1.
- Launch decision at edge N (IDLE) → `tx_enable`=1 during cycle N+1 only; transmitter raises `tx_busy` at N+2.
- `tx_busy` falls at edge M → `frame_sent` high M+1; earliest next `tx_enable` at M+2.
- Reset mid-frame: all state cleared at the reset edge; transmitter is reset by the same `rst_n`.

## Configuration
- `UART_TX_SCHED_IRQ_EN` defined: `tx_irq` registered, high while `sched_en && fifo_count <= THRESH`; clears one cycle after count exceeds THRESH or `sched_en` falls.
- Not defined: threshold logic omitted, `tx_irq` tied 0.

## Test plan
- Write 0x55, 0xA3, 0x0F with `sched_en`=1, `cfg_in`=5'b00011 → three `tx_enable` pulses in order, `tx_data` 0x55/0xA3/0x0F, three `frame_sent` pulses, then `sched_idle`=1.
- Write DEPTH+1 bytes with `sched_en`=0 → `fifo_full`=1, `fifo_count`=DEPTH, one `ovf` pulse, last byte absent from output.
- Change `cfg_in` 5'b00011→5'b11111 mid-frame → `cfg_reg` stays 5'b00011 until next launch, then 5'b11111.
- Assert `flush` during WAIT_DONE with 4 bytes queued → in-flight frame completes with `frame_sent`, count 0, no further launches.
- Simultaneous write and launch with count 1 → count stays 1, next frame launched after `frame_sent`.
- With `UART_TX_SCHED_IRQ_EN`, THRESH=4: fill to 6, drain → `tx_irq` rises when count reaches 4; without macro `tx_irq` stays 0.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched -- transmit scheduler between the APB register block and the
// UART transmitter.
//
// Software writes bytes into a DEPTH-entry FIFO. While sched_en is high the
// scheduler pops one byte at a time, latches the frame configuration along
// with it and launches the frame with a one-cycle tx_enable pulse. It then
// waits for the transmitter to raise tx_busy and later drop it. Latching
// tx_data/cfg_reg at launch keeps the frame intact if software rewrites the
// configuration while the frame is on the wire.
//
// Optional feature: define UART_TX_SCHED_IRQ_EN to build the low-water
// interrupt (tx_irq high while sched_en && fifo_count <= THRESH). If the macro
// is not defined, tx_irq is tied low.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   sched_en          allow new frame launches
//   cfg_in[4:0]       live frame config ([1:0] bits-5, [2] 2 stop, [3] par en, [4] odd)
//   wr_valid, wr_data software write strobe and byte
//   wr_ready          FIFO not full
//   flush             discard all queued bytes
//   tx_enable         one-cycle launch pulse to the transmitter
//   tx_data, cfg_reg  byte and config latched at launch
//   tx_busy           transmitter busy
//   fifo_count/empty/full  registered FIFO level and flags
//   sched_idle        no frame in flight and FIFO empty
//   frame_sent        one-cycle pulse per completed frame
//   ovf               one-cycle pulse when a write is dropped on a full FIFO
//   tx_irq            low-water interrupt
module uart_tx_sched #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int THRESH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sched_en,
  input  logic [4:0]    cfg_in,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          flush,
  output logic          tx_enable,
  output logic [7:0]    tx_data,
  output logic [4:0]    cfg_reg,
  input  logic          tx_busy,
  output logic [AW:0]   fifo_count,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          sched_idle,
  output logic          frame_sent,
  output logic          ovf,
  output logic          tx_irq
);

  if (DEPTH != (1 << AW)) begin : g_bad_depth
    $error("uart_tx_sched: DEPTH must equal 2**AW");
  end
  if (THRESH < 0 || THRESH >= DEPTH) begin : g_bad_thresh
    $error("uart_tx_sched: THRESH must be in [0, DEPTH)");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic          launch;
  logic          done;
  logic          wr_acc;
  logic [AW:0]   count_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];

  // A write is taken only if the FIFO was not full at the start of the cycle;
  // a same-cycle pop does not make room. flush discards the write outright.
  assign wr_acc = wr_valid && !fifo_full && !flush;

  // ---------------------------------------------------------------------------
  // FSM: next state and launch/complete strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sched_en && !fifo_empty && !tx_busy && !flush) begin
          launch  = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FIFO level
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = fifo_count;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({wr_acc, launch})
        2'b10:   count_d = fifo_count + 1'b1;
        2'b01:   count_d = fifo_count - 1'b1;
        default: count_d = fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      tx_enable  <= 1'b0;
      tx_data    <= '0;
      cfg_reg    <= '0;
      frame_sent <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      // Flags come from the next count so they are registered alongside it.
      fifo_count <= count_d;
      fifo_empty <= (count_d == '0);
      fifo_full  <= (count_d == DEPTH_C);
      tx_enable  <= launch;
      frame_sent <= done;
      ovf        <= wr_valid && fifo_full && !flush;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (launch) rd_ptr <= rd_ptr + 1'b1;
      end
      // Latched only at launch: held steady until the next frame starts.
      if (launch) begin
        tx_data <= mem[rd_ptr];
        cfg_reg <= cfg_in;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only read
  // after being written, and leaving reset off lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  assign wr_ready   = !fifo_full;
  assign sched_idle = (state_q == IDLE) && fifo_empty;

`ifdef UART_TX_SCHED_IRQ_EN
  localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);

  always_ff @(posedge clk) begin
    if (!rst_n) tx_irq <= 1'b0;
    else        tx_irq <= sched_en && (fifo_count <= THRESH_C);
  end
`else
  assign tx_irq = 1'b0;
`endif

endmodule
